jbus_sched: RTL
===============

# jbus_sched

Round-robin scheduler for the shared 8-bit tri-state CPU bus. N register/ALU sources each drive the bus through their own 8-bit enabler. The scheduler grants the bus to one source at a time and sequences the transfer: enable, then settle, then set the destination, then release. It also drives the bus-1 control that forces the bus value to 0x01 during the transfer, and pulses the destination register's set line.

## Interface
Parameters:
- N, 4, number of requesters (2..8)
- AW, 3, destination index width; ND = 2**AW destination set lines

Ports:
- wclk  in  1  clock, all state on rising edge
- wrstn  in  1  reset, asynchronous, active-low
- breq  in  N  per-requester bus request, level, held until wdone seen with own grant
- bdst  in  N*AW  destination index of requester j at bits [j*AW +: AW]
- bb1  in  N  requester j wants bus-1 forcing for its transfer
- bgnt  out  N  one-hot grant, held for GRANT..DONE
- benable  out  N  one-hot enabler control (we) for the granted source
- bset  out  ND  one-hot destination set pulse
- wbit1  out  1  to the bus-1 block; high while the winner's bb1 was latched, during DRIVE and SET
- wdone  out  1  one-cycle transfer-complete pulse
- wbusy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, GRANT, DRIVE, SET, DONE. Encoding is free.
- IDLE: if any breq bit is set, pick the winner round-robin starting at pointer rp, latch the winner, bdst[winner] and bb1[winner], and go to GRANT. Otherwise stay in IDLE.
- GRANT -> DRIVE -> SET -> DONE. These transitions are unconditional, one cycle each.
- DONE: set rp to (winner+1) mod N. Re-arbitrate in the same cycle with the current winner's breq bit masked:
  - if another request is pending, go to GRANT;
  - otherwise go to IDLE.
- Output decode, all registered or decoded from registered state; no combinational path from breq to outputs:
  - bgnt[winner]=1 in GRANT, DRIVE, SET and DONE.
  - benable[winner]=1 in DRIVE and SET only.
  - bset[dst]=1 in SET only. Exactly one bit is set, where dst is the latched index.
  - wbit1 = latched bb1 in DRIVE and SET; 0 elsewhere.
  - wdone=1 in DONE only.
- Latched winner, dst and bb1 are not affected by input changes after the latch.
- A requester dropping breq mid-transfer does not abort the transfer; the transfer completes normally.
- At most one benable bit and at most one bset bit are high in any cycle. A bench assertion is required for both.
- Arbitration sees breq == 0 -> no grant; the scheduler stays idle indefinitely.
- N not a power of two: rp wraps from N-1 to 0.

## Timing
- Reset values, while wrstn=0 (asynchronous, immediate):
  - state IDLE, rp=0, latches 0;
  - bgnt, benable, bset, wbit1, wdone and wbusy all 0.
- Reset mid-transfer: outputs drop to 0 without waiting for a clock edge. After release, the first arbitration starts from rp=0.
- Latency: breq sampled high at edge k in IDLE gives bgnt high in cycle k+1.
  - benable in k+2..k+3, bset in k+3, wdone in k+4.
- Back-to-back transfers: DONE -> GRANT, i.e. 4 cycles per transfer with continuous requests from different requesters.
- Same requester repeating: goes through IDLE, 5 cycles per transfer.
- The bus settles for one full cycle (DRIVE) before the set edge. Enable is held through SET, so the destination captures stable data.
- Requester protocol: deassert breq in the cycle after seeing wdone with its own bgnt bit. Holding breq asserted requests another transfer.

## Test plan
- Single request: after reset, breq=0b0100, bdst[2]=5, bb1=0 -> bgnt=0b0100 in cycles 1-4; benable=0b0100 in cycles 2-3; bset=0x20 in cycle 3 only; wdone in cycle 4; wbit1 stays 0; idle in cycle 5.
- Round-robin fairness: breq=0b1111 held continuously -> grant order 0,1,2,3,0; transfers spaced 4 cycles apart; wbusy stays high.
- Bus-1 forcing: breq=0b0001, bb1=0b0001, bdst[0]=0 -> wbit1=1 in DRIVE and SET only; bset=0x01 in SET.
- Input change mid-transfer: breq=0b0010 with bdst[1]=3, then in the DRIVE cycle change bdst[1]=7 and drop breq -> bset=0x08 in SET; wdone is still pulsed; then IDLE.
- Reset mid-transfer: assert wrstn=0 asynchronously during SET -> all outputs 0 before the next edge. Release with breq=0b1010 -> requester 1 is granted first (rp=0).
- Solo repeat: breq=0b0001 held -> successive grants to requester 0 every 5 cycles. At no point is more than one benable or bset bit high.

Source files
------------

// File: rtl/jbus_sched_if.sv
// ---------------------------------------------------------------------------
// jbus_sched_if
// Groups the request side and the control outputs of the CPU bus scheduler.
//   breq    : per-requester level request
//   bdst    : per-requester destination index, requester j at [j*AW +: AW]
//   bb1     : per-requester bus-1 forcing request
//   bgnt    : one-hot grant to the current winner
//   benable : one-hot enabler control for the granted source
//   bset    : one-hot destination set pulse
//   wbit1   : bus-1 forcing control
//   wdone   : one-cycle transfer-complete pulse
//   wbusy   : scheduler is not idle
// The master modport is the scheduler; the slave modport is the requester side.
// ---------------------------------------------------------------------------
interface jbus_sched_if #(
   parameter int N  = 4,
   parameter int AW = 3
);
   localparam int ND = 2**AW;

   logic [N-1:0]    breq;
   logic [N*AW-1:0] bdst;
   logic [N-1:0]    bb1;
   logic [N-1:0]    bgnt;
   logic [N-1:0]    benable;
   logic [ND-1:0]   bset;
   logic            wbit1;
   logic            wdone;
   logic            wbusy;

   modport master (
      input  breq, bdst, bb1,
      output bgnt, benable, bset, wbit1, wdone, wbusy
   );

   modport slave (
      output breq, bdst, bb1,
      input  bgnt, benable, bset, wbit1, wdone, wbusy
   );
endinterface

// File: rtl/jbus_sched.sv
// ---------------------------------------------------------------------------
// jbus_sched
// Round-robin scheduler for the shared 8-bit tri-state CPU bus. One source is
// granted at a time and its transfer is sequenced GRANT -> DRIVE -> SET -> DONE:
// the source enabler is switched on, the bus settles for a full cycle, the
// destination set line is pulsed, then the grant is released.
// Ports:
//   wclk  : clock, all state on the rising edge
//   wrstn : asynchronous active-low reset
//   bus   : jbus_sched_if master modport (requests in, bus controls out)
// All outputs are decoded from registered state only.
// ---------------------------------------------------------------------------
module jbus_sched #(
   parameter int N  = 4,
   parameter int AW = 3
) (
   input  logic         wclk,
   input  logic         wrstn,
   jbus_sched_if.master bus
);
   localparam int ND = 2**AW;
   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int SW = PW + 1;

   typedef enum logic [2:0] {IDLE, GRANT, DRIVE, SET, DONE} state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] rp_q, rp_d;
   logic [PW-1:0] win_q, win_d;
   logic [AW-1:0] dst_q, dst_d;
   logic          b1_q, b1_d;

   logic [N-1:0]  arbReq;
   logic [PW-1:0] arbStart;
   logic [PW-1:0] nextPtr;
   logic [PW-1:0] pickIdx;
   logic          pickFound;
   logic [SW-1:0] scanIdx;
   logic [AW-1:0] pickDst;

   logic [N-1:0]  winHot;
   logic [ND-1:0] dstHot;
   logic [N-1:0]  bgntD;
   logic [N-1:0]  benableD;
   logic [ND-1:0] bsetD;
   logic          wbit1D;
   logic          wdoneD;

   // Successor of the current winner; wraps explicitly so N need not be a
   // power of two.
   always_comb begin
      if (win_q == PW'(N - 1)) begin
         nextPtr = '0;
      end else begin
         nextPtr = win_q + 1'b1;
      end
   end

   // Round-robin scan. In DONE the arbitration already starts from the
   // successor of the finishing winner and ignores that winner, so a different
   // pending requester gets the bus back-to-back; a lone repeat goes via IDLE.
   always_comb begin
      arbReq    = bus.breq;
      arbStart  = rp_q;
      pickFound = 1'b0;
      pickIdx   = '0;
      scanIdx   = '0;
      if (state_q == DONE) begin
         arbReq[win_q] = 1'b0;
         arbStart      = nextPtr;
      end
      for (int i = 0; i < N; i++) begin
         scanIdx = {1'b0, arbStart} + SW'(i);
         if (scanIdx >= SW'(N)) begin
            scanIdx = scanIdx - SW'(N);
         end
         if (!pickFound && arbReq[scanIdx[PW-1:0]]) begin
            pickFound = 1'b1;
            pickIdx   = scanIdx[PW-1:0];
         end
      end
   end

   // Destination index of the requester about to win.
   always_comb begin
      pickDst = '0;
      for (int j = 0; j < N; j++) begin
         if (pickIdx == PW'(j)) begin
            pickDst = bus.bdst[j*AW +: AW];
         end
      end
   end

   // Next-state logic. Winner, destination and bus-1 request are captured only
   // at the arbitration point and held untouched for the whole transfer.
   always_comb begin
      state_d = state_q;
      rp_d    = rp_q;
      win_d   = win_q;
      dst_d   = dst_q;
      b1_d    = b1_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (state_q == DONE) begin
               rp_d = nextPtr;
            end
            if (pickFound) begin
               state_d = GRANT;
               win_d   = pickIdx;
               dst_d   = pickDst;
               b1_d    = bus.bb1[pickIdx];
            end else begin
               state_d = IDLE;
            end
         end
         GRANT:   state_d = DRIVE;
         DRIVE:   state_d = SET;
         SET:     state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wclk or negedge wrstn) begin
      if (!wrstn) begin
         state_q <= IDLE;
         rp_q    <= '0;
         win_q   <= '0;
         dst_q   <= '0;
         b1_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rp_q    <= rp_d;
         win_q   <= win_d;
         dst_q   <= dst_d;
         b1_q    <= b1_d;
      end
   end

   // Output decode from registered state. Enable spans DRIVE and SET so the
   // destination captures data that has been stable for a full cycle.
   always_comb begin
      winHot        = '0;
      winHot[win_q] = 1'b1;
      dstHot        = '0;
      dstHot[dst_q] = 1'b1;
      bgntD         = '0;
      benableD      = '0;
      bsetD         = '0;
      wbit1D        = 1'b0;
      wdoneD        = 1'b0;
      unique case (state_q)
         GRANT: begin
            bgntD = winHot;
         end
         DRIVE: begin
            bgntD    = winHot;
            benableD = winHot;
            wbit1D   = b1_q;
         end
         SET: begin
            bgntD    = winHot;
            benableD = winHot;
            bsetD    = dstHot;
            wbit1D   = b1_q;
         end
         DONE: begin
            bgntD  = winHot;
            wdoneD = 1'b1;
         end
         default: begin
            bgntD = '0;
         end
      endcase
   end

   assign bus.bgnt    = bgntD;
   assign bus.benable = benableD;
   assign bus.bset    = bsetD;
   assign bus.wbit1   = wbit1D;
   assign bus.wdone   = wdoneD;
   assign bus.wbusy   = (state_q != IDLE);

endmodule
